// File: rtl/atomrvcore_pkg.sv
// Purpose: shared types and constants for the atomRVCORE fetch path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: fetch_entry_t {pc, instr}, NOP_INSTR filler, default reset PC.
package atomrvcore_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0 -- presented on instr_o whenever the queue is empty.
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/atomrvcore_sync_fifo.sv
// Purpose: DEPTH-entry circular buffer of fetch_entry_t with synchronous flush.
// Latency: push visible at head the cycle after the write; no bypass.
// Backpressure: none internally; the caller must never push when full or pop when empty.
// Ports: clk, rst_n (async active-low), flush, push/push_data, pop, head, count.
module atomrvcore_sync_fifo
  import atomrvcore_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage is not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/atomrvcore_fetch_queue.sv
// Purpose: fetch stage owning the PC; sequential ICCM reads buffered in a queue for the IDU.
// Latency: address in cycle N, data captured end of N+1, instr_valid_o in N+2.
// Backpressure: reads are issued only while queue occupancy plus the in-flight read is below DEPTH.
// Ports: clk_i, rst_ni; redirect_i/redirect_pc_i from IDU; IR_EN_o/address_o/DATA_i to ICCM;
//        instr_valid_o/instr_ready_i/instr_o/pc_o to IDU; count_o occupancy.
module atomrvcore_fetch_queue
  import atomrvcore_pkg::*;
#(
  parameter int                   DATAWIDTH = 32,
  parameter int                   ADDRWIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = ADDRWIDTH'(DEFAULT_RESET_PC),
  localparam int                  CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 redirect_i,
  input  logic [ADDRWIDTH-1:0] redirect_pc_i,
  output logic                 IR_EN_o,
  output logic [ADDRWIDTH-1:0] address_o,
  input  logic [DATAWIDTH-1:0] DATA_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [ADDRWIDTH-1:0] pc_o,
  output logic [CW-1:0]        count_o
);

  // fetch_entry_t fields are XLEN wide, so DATAWIDTH and ADDRWIDTH are expected to equal XLEN.

  logic [ADDRWIDTH-1:0] pc_q;
  logic [ADDRWIDTH-1:0] inflight_pc_q;
  logic                 inflight_vld_q;
  logic [CW-1:0]        count;
  logic [CW:0]          credits_used;
  logic                 issue;
  logic                 push;
  logic                 pop;
  fetch_entry_t         resp;
  fetch_entry_t         head;

  // Credit check from registered state only: every issued read is guaranteed a slot.
  assign credits_used = {1'b0, count} + {{CW{1'b0}}, inflight_vld_q};
  assign issue        = credits_used < (CW + 1)'(DEPTH);
  assign IR_EN_o      = issue;
  assign address_o    = pc_q;

  assign instr_valid_o = (count != '0);
  assign pop           = instr_valid_o && instr_ready_i;

  // A response landing in a redirect cycle belongs to the old path and is dropped.
  assign push = inflight_vld_q && !redirect_i;
  assign resp = '{pc: inflight_pc_q, instr: DATA_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q           <= RESET_PC;
      inflight_vld_q <= 1'b0;
      inflight_pc_q  <= '0;
    end else if (redirect_i) begin
      // Any read issued this cycle is killed by never marking it in flight.
      pc_q           <= {redirect_pc_i[ADDRWIDTH-1:2], 2'b00};
      inflight_vld_q <= 1'b0;
    end else begin
      inflight_vld_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + ADDRWIDTH'(4);
        inflight_pc_q <= pc_q;
      end
    end
  end

  atomrvcore_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (redirect_i),
    .push      (push),
    .push_data (resp),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign instr_o = instr_valid_o ? head.instr : NOP_INSTR;
  assign pc_o    = head.pc;
  assign count_o = count;

endmodule
